// File: rtl/fir_filter_mc_if.sv
// rtl/fir_filter_mc_if.sv - sample, result and coefficient signals of fir_filter_mc
interface fir_filter_mc_if #(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int TAPS     = 8,
  parameter int CHANNELS = 2
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW   = $clog2(TAPS);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CH_W-1:0]   in_chan;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CH_W-1:0]   out_chan;
  logic              bypass;
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic              coef_drop;

  modport master (
    output in_valid, in_data, in_chan, out_ready, bypass, coef_we, coef_addr, coef_data,
    input  in_ready, out_valid, out_data, out_chan, coef_drop
  );

  modport slave (
    input  in_valid, in_data, in_chan, out_ready, bypass, coef_we, coef_addr, coef_data,
    output in_ready, out_valid, out_data, out_chan, coef_drop
  );
endinterface

// File: rtl/fir_filter_mc.sv
// rtl/fir_filter_mc.sv - time-multiplexed multi-channel FIR, one MAC per cycle
// Define FIR_SAT_EN to saturate the rounded result; otherwise it wraps to DATA_W bits.
module fir_filter_mc #(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int TAPS     = 8,
  parameter int CHANNELS = 2
) (
  input  logic           clk,
  input  logic           reset,
  fir_filter_mc_if.slave bus
);
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW     = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + AW;

  localparam logic [AW-1:0]           LAST_TAP  = AW'(TAPS - 1);
  localparam logic [AW:0]             TAPS_W    = (AW + 1)'(TAPS);
  localparam logic [CH_W:0]           CHAN_LIM  = (CH_W + 1)'(CHANNELS);
  localparam logic signed [ACC_W-1:0] RND       = ACC_W'(1) << (COEF_W - 2);
  localparam logic [COEF_W-1:0]       COEF_UNIT = {1'b0, {(COEF_W-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                   state, stateNext;
  logic signed [DATA_W-1:0] delayLine [CHANNELS][TAPS];
  logic [AW-1:0]            wrPtr [CHANNELS];
  logic signed [COEF_W-1:0] coef [TAPS];
  logic [CH_W-1:0]          chanQ;
  logic                     bypassQ;
  logic signed [DATA_W-1:0] sampleQ;
  logic [AW-1:0]            tapCnt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] outDataQ;
  logic                     coefDropQ;

  logic                     accept, chanOk, lastTap;
  logic [AW-1:0]            rdIdx;
  logic signed [DATA_W-1:0] xK;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  accNext, rounded;
  logic signed [DATA_W-1:0] result;

  assign accept  = bus.in_valid && (state == IDLE);
  assign chanOk  = {1'b0, bus.in_chan} < CHAN_LIM;
  assign lastTap = (tapCnt == LAST_TAP);

  // x[n-k] lives k slots behind the newest sample, wrapping inside the TAPS-deep ring
  assign rdIdx   = (wrPtr[chanQ] >= tapCnt) ? (wrPtr[chanQ] - tapCnt)
                                            : AW'({1'b0, wrPtr[chanQ]} + TAPS_W - {1'b0, tapCnt});
  assign xK      = delayLine[chanQ][rdIdx];
  assign prod    = coef[tapCnt] * xK;
  assign accNext = acc + ACC_W'(prod);
  assign rounded = (accNext + RND) >>> (COEF_W - 1);

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  always_comb begin
    result = DATA_W'(rounded);
    if (rounded > SAT_MAX)      result = DATA_W'(SAT_MAX);
    else if (rounded < SAT_MIN) result = DATA_W'(SAT_MIN);
  end
`else
  assign result = DATA_W'(rounded);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept && chanOk) stateNext = MAC;
      MAC:     if (lastTap) stateNext = OUT;
      OUT:     if (bus.out_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wrPtr[c] <= '0;
        for (int t = 0; t < TAPS; t++) delayLine[c][t] <= '0;
      end
      for (int t = 0; t < TAPS; t++) coef[t] <= (t == 0) ? COEF_UNIT : '0;
      chanQ     <= '0;
      bypassQ   <= 1'b0;
      sampleQ   <= '0;
      tapCnt    <= '0;
      acc       <= '0;
      outDataQ  <= '0;
      coefDropQ <= 1'b0;
    end else begin
      coefDropQ <= bus.coef_we && (state != IDLE);
      case (state)
        IDLE: begin
          // coefficient write lands before the MAC of a same-cycle sample reads it
          if (bus.coef_we && ({1'b0, bus.coef_addr} < TAPS_W)) coef[bus.coef_addr] <= bus.coef_data;
          if (accept && chanOk) begin
            delayLine[bus.in_chan][wrPtr[bus.in_chan]] <= bus.in_data;
            chanQ   <= bus.in_chan;
            bypassQ <= bus.bypass;
            sampleQ <= bus.in_data;
            acc     <= '0;
            tapCnt  <= '0;
          end
        end
        MAC: begin
          acc    <= accNext;
          tapCnt <= tapCnt + 1'b1;
          if (lastTap) begin
            wrPtr[chanQ] <= (wrPtr[chanQ] == LAST_TAP) ? '0 : wrPtr[chanQ] + 1'b1;
            outDataQ     <= bypassQ ? sampleQ : result;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == OUT);
  assign bus.out_data  = outDataQ;
  assign bus.out_chan  = chanQ;
  assign bus.coef_drop = coefDropQ;
endmodule
